// File: rtl/rf_wport_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wport_arbiter
//
// Shares the register file's single write port between the in-order pipeline
// writeback (port A) and the multi-cycle execution unit (port B).
// Round-robin arbitration with valid/ready handshakes. The winning write is
// registered once before it drives the register file's we3/a3/wd3 port.
// A busy scoreboard tracks registers that are waiting for multi-cycle
// results. The decode stage gets a combinational hazard flag from it.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   a_valid/a_addr/a_data port A request (pipeline writeback)
//   a_ready               port A granted this cycle (combinational)
//   b_valid/b_addr/b_data port B request (multi-cycle unit)
//   b_ready               port B granted this cycle (combinational)
//   sb_set, sb_addr       multi-cycle op issued; mark sb_addr busy
//   q_rs1, q_rs2, q_rd    decode-stage register query
//   hazard                decode must stall (combinational)
//   rf_we3/rf_a3/rf_wd3   registered register-file write port
//   sb_err                sticky scoreboard protocol error
//   conflict_cnt          saturating count of cycles with both valids high
// ---------------------------------------------------------------------------
module rf_wport_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int CW   = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_addr,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [AW-1:0]   b_addr,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_addr,
    input  logic [AW-1:0]   q_rs1,
    input  logic [AW-1:0]   q_rs2,
    input  logic [AW-1:0]   q_rd,
    output logic            hazard,
    output logic            rf_we3,
    output logic [AW-1:0]   rf_a3,
    output logic [XLEN-1:0] rf_wd3,
    output logic            sb_err,
    output logic [CW-1:0]   conflict_cnt
);

    localparam int NREG = 1 << AW;

    // Which requester won the most recent transfer.
    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_e;

    last_e            last_q, last_d;
    logic             rf_we3_q, rf_we3_d;
    logic [AW-1:0]    rf_a3_q, rf_a3_d;
    logic [XLEN-1:0]  rf_wd3_q, rf_wd3_d;
    logic [NREG-1:0]  busy_q, busy_d;
    logic             sb_err_q, sb_err_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic a_xfer;
    logic b_xfer;
    logic set_dup;
    logic clr_idle;

    // -----------------------------------------------------------------------
    // Grant. Ready depends only on the valids and the pointer. While reset is
    // asserted no requester is granted, so no transfer can happen.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so
        // no path can leave it unassigned and infer a latch.
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (reset_n) begin
            if (a_valid && b_valid) begin
                a_ready = (last_q == LAST_B);
                b_ready = (last_q == LAST_A);
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    assign a_xfer = a_valid && a_ready;
    assign b_xfer = b_valid && b_ready;

    // -----------------------------------------------------------------------
    // Next-state logic: pointer, write stage, scoreboard, error, counter.
    // -----------------------------------------------------------------------
    always_comb begin
        last_d   = last_q;
        rf_we3_d = 1'b0;
        rf_a3_d  = rf_a3_q;
        rf_wd3_d = rf_wd3_q;

        // At most one of a_xfer/b_xfer is high.
        if (a_xfer) begin
            last_d   = LAST_A;
            rf_a3_d  = a_addr;
            rf_wd3_d = a_data;
            rf_we3_d = (a_addr != '0);   // r0 writes handshake but are dropped
        end else if (b_xfer) begin
            last_d   = LAST_B;
            rf_a3_d  = b_addr;
            rf_wd3_d = b_data;
            rf_we3_d = (b_addr != '0);
        end

        // Apply the clear before the set so a same-cycle set wins.
        busy_d = busy_q;
        if (b_xfer) begin
            busy_d[b_addr] = 1'b0;
        end
        if (sb_set && (sb_addr != '0)) begin
            busy_d[sb_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;

        // A second issue to a register that is still busy, unless that
        // register's result retires in this same cycle.
        set_dup  = sb_set && (sb_addr != '0) && busy_q[sb_addr]
                   && !(b_xfer && (b_addr == sb_addr));
        // A multi-cycle result for a register that nothing was waiting on.
        clr_idle = b_xfer && (b_addr != '0) && !busy_q[b_addr];
        sb_err_d = sb_err_q || set_dup || clr_idle;

        cnt_d = cnt_q;
        if (a_valid && b_valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Hazard. A register is unsafe to read if it is busy, or if its write is
    // sitting in the output stage. The register file only picks that write up
    // at the next edge, so a read this cycle would still see the old value.
    // That second term also keeps the stall going through the cycle in which
    // the busy bit has already cleared.
    // -----------------------------------------------------------------------
    function automatic logic reg_hazard(input logic [AW-1:0] q);
        return busy_q[q] || (rf_we3_q && (rf_a3_q == q) && (q != '0));
    endfunction

    always_comb begin
        hazard = reg_hazard(q_rs1) || reg_hazard(q_rs2) || reg_hazard(q_rd);
    end

    // -----------------------------------------------------------------------
    // State registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples pre-edge values no matter what order the statements are in.
        if (!reset_n) begin
            last_q   <= LAST_B;
            rf_we3_q <= 1'b0;
            rf_a3_q  <= '0;
            rf_wd3_q <= '0;
            // NOTE: busy is a flop vector, not a RAM. It has to be cleared
            // here because stale busy bits after reset would stall decode.
            busy_q   <= '0;
            sb_err_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            last_q   <= last_d;
            rf_we3_q <= rf_we3_d;
            rf_a3_q  <= rf_a3_d;
            rf_wd3_q <= rf_wd3_d;
            busy_q   <= busy_d;
            sb_err_q <= sb_err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rf_we3       = rf_we3_q;
    assign rf_a3        = rf_a3_q;
    assign rf_wd3       = rf_wd3_q;
    assign sb_err       = sb_err_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Shares the register file's single write port between two requesters: the in-order pipeline writeback (port A) and the multi-cycle execution unit (port B). Uses round-robin arbitration with valid/ready handshakes and drives the register file's write port (`we3`/`a3`/`wd3`) through one registered stage. Holds a 32-entry busy scoreboard for registers with outstanding multi-cycle results, and gives the decode stage a combinational hazard flag.

## Interface

- `XLEN`, 32, data width of the register file.
- `AW`, 5, register address width (2^AW registers).
- `CW`, 16, width of the conflict counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `a_valid`  in  1  writeback request from the pipeline.
- `a_addr`  in  AW  destination register for port A.
- `a_data`  in  XLEN  write data for port A.
- `a_ready`  out  1  port A granted this cycle.
- `b_valid`  in  1  writeback request from the multi-cycle unit.
- `b_addr`  in  AW  destination register for port B.
- `b_data`  in  XLEN  write data for port B.
- `b_ready`  out  1  port B granted this cycle.
- `sb_set`  in  1  multi-cycle op issued; marks `sb_addr` busy.
- `sb_addr`  in  AW  destination register of the issued op.
- `q_rs1`, `q_rs2`, `q_rd`  in  AW each  decode-stage operand and destination query.
- `hazard`  out  1  combinational; decode must stall.
- `rf_we3`  out  1  register file write enable (registered).
- `rf_a3`  out  AW  register file write address (registered).
- `rf_wd3`  out  XLEN  register file write data (registered).
- `sb_err`  out  1  sticky scoreboard protocol error.
- `conflict_cnt`  out  CW  saturating count of cycles with both requests valid.

## Operation

- **Handshake:** a transfer occurs on a cycle where valid and ready are both 1.
  - A requester holds valid, addr and data stable until its transfer.
  - Valid must not depend on ready.
  - Ready is combinational from the valids and the priority pointer.
- **Arbitration:**
  - Only one requester valid: it is granted.
  - Both valid: the requester that did not win the last transfer is granted.
  - Pointer `last` updates only on a transfer. Its reset value is B, so A wins the first tie.
  - Exactly one of `a_ready`/`b_ready` is high when any valid is high. Both are low when no valid is high.
- **Write stage:**
  - On a transfer, the winner's addr and data load `rf_a3`/`rf_wd3`.
  - `rf_we3` loads 1 if addr ≠ 0, else 0. Writes to r0 complete the handshake but are dropped.
  - With no transfer, `rf_we3` loads 0. `rf_a3`/`rf_wd3` hold their values.
- **Scoreboard:** `busy[2^AW]`.
  - `sb_set` with `sb_addr` ≠ 0 sets `busy[sb_addr]`. `sb_addr` = 0 is ignored.
  - A port-B transfer clears `busy[b_addr]`.
  - Set and clear to the same address in the same cycle: set wins.
  - Port-A transfers never touch the scoreboard.
  - `busy[0]` is always 0.
- **Hazard:** `hazard` = 1 if, for any of `q_rs1`/`q_rs2`/`q_rd`, either condition holds:
  - `busy[q]` = 1;
  - `rf_we3` = 1 and `rf_a3` = q, with q ≠ 0 (the write lands at the next edge and the register file read is still stale).
- **`sb_err`:** set and held until reset on either event:
  - `sb_set` to an already-busy register, with no same-cycle clear of that register;
  - a port-B transfer to a non-busy register with b_addr ≠ 0.
- **`conflict_cnt`:** increments every cycle with `a_valid` and `b_valid` both high. It saturates at 2^CW−1.

## Timing

- **Reset (`reset_n` = 0 at an edge):**
  - Cleared: `rf_we3`, `rf_a3`, `rf_wd3`, all `busy`, `sb_err`, `conflict_cnt`.
  - `last` = B.
  - While `reset_n` = 0, `a_ready` = `b_ready` = 0, so no transfer occurs.
  - `hazard` follows from the cleared state, so it is 0.
- **Reset mid-operation:** any in-flight registered write is discarded (`rf_we3` = 0 after the edge). Pending busy bits are lost.
- **Latency:** transfer at edge N gives `rf_we3` high for the cycle after N. The register file is written at edge N+1. A read of that register returns the new value from cycle N+1 onward.
- **Throughput:** one write per cycle. Under continuous contention, grants alternate A, B, A, B.
- **Busy clear timing:** the busy bit clears at edge N. The `rf_a3` match keeps `hazard` high through cycle N, so the stall has no gap.

## Test plan

- **Reset state:** hold `reset_n` = 0 for 2 cycles with `a_valid` = `b_valid` = 1 → both readies 0, `rf_we3` = 0, `hazard` = 0, `conflict_cnt` = 0.
- **Single writer:** A only, addr 5, data 0xDEADBEEF → `a_ready` = 1 the same cycle; next cycle `rf_we3` = 1, `rf_a3` = 5, `rf_wd3` = 0xDEADBEEF. Then addr 0 → handshake completes and `rf_we3` stays 0.
- **Contention:** A and B continuously valid for 4 cycles → grants A, B, A, B; `conflict_cnt` = 4.
- **Scoreboard/hazard:**
  - `sb_set` addr 7; `q_rs1` = 7 → `hazard` = 1 from the next cycle.
  - B writes 7 → `hazard` remains 1 through the `rf_we3` cycle, then falls to 0.
  - `sb_err` stays 0 throughout.
- **Simultaneous set/clear:** `sb_set` addr 9 in the same cycle as a B transfer to 9 → `busy[9]` remains 1, `sb_err` = 0.
- **Protocol errors:** `sb_set` 3 twice with no clear → `sb_err` = 1 and it stays 1. After reset, a B write to non-busy register 4 → `sb_err` = 1.
